// File: rtl/lb_window_ctrl.sv
// lb_window_ctrl: frame sequencer for a 3-row line buffer feeding a 3x3
// convolution. It gates the pixel stream, drives the line buffer shift
// enable, tracks the row/column position and flags every cycle where the
// line buffer taps plus the downstream column register hold a full window.
module lb_window_ctrl #(
  parameter int WIDTH  = 416,
  parameter int HEIGHT = 416,
  parameter int STRIDE = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic                      lb_valid_in,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [$clog2(HEIGHT)-1:0] m_row,
  output logic [$clog2(WIDTH)-1:0]  m_col,
  output logic                      frame_done,
  output logic                      busy
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            m_valid_q, m_valid_d;
  logic [RW-1:0]   m_row_q, m_row_d;
  logic [CW-1:0]   m_col_q, m_col_d;

  logic            accept;
  logic            last_col;
  logic            last_pix;
  logic            stride_ok;
  logic            win;
  logic [RW-1:0]   row_off;
  logic [CW-1:0]   col_off;
  logic [RW-1:0]   win_row;
  logic [CW-1:0]   win_col;

  // A held window blocks the stream so the line buffer and taps freeze with it.
  assign s_ready     = (state_q == RUN) && (!m_valid_q || m_ready);
  assign accept      = s_valid && s_ready;
  assign lb_valid_in = accept;

  assign last_col = (col_q == CW'(WIDTH - 1));
  assign last_pix = last_col && (row_q == RW'(HEIGHT - 1));

  // For stride 2 the window origin sits on even rows/columns (r-2 even <=> r even).
  assign stride_ok = (STRIDE == 2) ? (!row_q[0] && !col_q[0]) : 1'b1;
  assign win       = (row_q >= RW'(2)) && (col_q >= CW'(2)) && stride_ok;

  assign row_off = row_q - RW'(2);
  assign col_off = col_q - CW'(2);
  assign win_row = (STRIDE == 2) ? (row_off >> 1) : row_off;
  assign win_col = (STRIDE == 2) ? (col_off >> 1) : col_off;

  assign m_valid    = m_valid_q;
  assign m_row      = m_row_q;
  assign m_col      = m_col_q;
  assign frame_done = (state_q == DONE);
  assign busy       = (state_q != IDLE);

  // State, position counters and the registered window descriptor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      m_valid_q <= 1'b0;
      m_row_q   <= '0;
      m_col_q   <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      m_valid_q <= m_valid_d;
      m_row_q   <= m_row_d;
      m_col_q   <= m_col_d;
    end
  end

  // Next-state logic: frame sequencing, position tracking, window flagging.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    m_valid_d = m_valid_q;
    m_row_d   = m_row_q;
    m_col_d   = m_col_q;

    // Downstream take retires the current window; a new one below overrides.
    if (m_ready) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          col_d   = '0;
          row_d   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          if (last_col) begin
            col_d = '0;
            // Row stays on the last line so it never wraps inside a frame.
            if (!last_pix) begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
          if (win) begin
            m_valid_d = 1'b1;
            m_row_d   = win_row;
            m_col_d   = win_col;
          end
          if (last_pix) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!m_valid_q || m_ready) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lb_window_ctrl.sv
// Directed bench for lb_window_ctrl on an 8x6 frame, with a stride-1 and a
// stride-2 instance sharing the same input stimulus.
module tb_lb_window_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       s_valid;
  logic       m_ready;

  logic       s_ready1, lb1, m_valid1, fd1, busy1;
  logic [2:0] m_row1, m_col1;
  logic       s_ready2, lb2, m_valid2, fd2, busy2;
  logic [2:0] m_row2, m_col2;

  int vectors     = 0;
  int miscompares = 0;

  int q1[$];
  int q2[$];
  int exp1[$];
  int exp2[$];
  int acc1, acc2, fd1_cnt, first_acc1;
  logic prev_mv1;

  always #5 clk = ~clk;

  lb_window_ctrl #(.WIDTH(8), .HEIGHT(6), .STRIDE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid),
    .s_ready(s_ready1), .lb_valid_in(lb1), .m_valid(m_valid1),
    .m_ready(m_ready), .m_row(m_row1), .m_col(m_col1),
    .frame_done(fd1), .busy(busy1)
  );

  lb_window_ctrl #(.WIDTH(8), .HEIGHT(6), .STRIDE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid),
    .s_ready(s_ready2), .lb_valid_in(lb2), .m_valid(m_valid2),
    .m_ready(m_ready), .m_row(m_row2), .m_col(m_col2),
    .frame_done(fd2), .busy(busy2)
  );

  // Monitor: record accepted windows, shift enables and frame_done pulses.
  always @(negedge clk) begin
    if (m_valid1 && !prev_mv1 && first_acc1 < 0) first_acc1 <= acc1;
    prev_mv1 <= m_valid1;
    if (m_valid1 && m_ready) q1.push_back(int'(m_row1) * 16 + int'(m_col1));
    if (m_valid2 && m_ready) q2.push_back(int'(m_row2) * 16 + int'(m_col2));
    if (lb1) acc1 <= acc1 + 1;
    if (lb2) acc2 <= acc2 + 1;
    if (fd1) fd1_cnt <= fd1_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_seq(input string tag, input int got[$], input int expq[$]);
    check({tag, "_count"}, got.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      if (i < got.size()) check($sformatf("%s_win%0d", tag, i), got[i], expq[i]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, s_ready1, 0);
    check({tag, "_lb_valid_in"}, lb1, 0);
    check({tag, "_m_valid"}, m_valid1, 0);
    check({tag, "_m_row"}, m_row1, 0);
    check({tag, "_m_col"}, m_col1, 0);
    check({tag, "_frame_done"}, fd1, 0);
    check({tag, "_busy"}, busy1, 0);
    check({tag, "_busy_s2"}, busy2, 0);
    check({tag, "_m_valid_s2"}, m_valid2, 0);
  endtask

  // Runs one frame on both instances; returns early when abort_at accepts are reached.
  task automatic run_frame(input bit bubbles, input bit do_stall, input bit poke_start,
                           input int abort_at);
    int cyc;
    int stall_left;
    bit stalled;
    bit aborted;
    q1.delete();
    q2.delete();
    acc1 = 0; acc2 = 0; fd1_cnt = 0; first_acc1 = -1;
    cyc = 0; stall_left = 0; stalled = 0; aborted = 0;
    start = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while ((busy1 || busy2) && cyc < 2000 && !aborted) begin
      if (abort_at > 0 && acc1 >= abort_at) begin
        aborted = 1;
      end else begin
        s_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
        m_ready = 1'b1;
        start   = 1'b0;
        if (do_stall && !stalled && m_valid1 && m_row1 == 3'd1 && m_col1 == 3'd3) begin
          stalled    = 1;
          stall_left = 5;
        end
        if (stall_left > 0) begin
          m_ready = 1'b0;
          #1;
          check("stall_s_ready", s_ready1, 0);
          check("stall_lb_valid_in", lb1, 0);
          check("stall_m_row", m_row1, 1);
          check("stall_m_col", m_col1, 3);
          stall_left--;
        end
        if (poke_start && (cyc == 10 || fd1)) start = 1'b1;
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    if (!aborted) check("frame_timeout", cyc >= 2000, 0);
    if (do_stall) check("stall_seen", stalled, 1);
  endtask

  task automatic check_frame(input string tag);
    @(negedge clk);
    check_seq({tag, "_s1"}, q1, exp1);
    check_seq({tag, "_s2"}, q2, exp2);
    check({tag, "_lb_count"}, acc1, 48);
    check({tag, "_frame_done_pulses"}, fd1_cnt, 1);
    check({tag, "_busy_after"}, busy1, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int r = 2; r < 6; r++)
      for (int c = 2; c < 8; c++) begin
        exp1.push_back((r - 2) * 16 + (c - 2));
        if ((r - 2) % 2 == 0 && (c - 2) % 2 == 0)
          exp2.push_back(((r - 2) / 2) * 16 + (c - 2) / 2);
      end

    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    acc1 = 0; acc2 = 0; fd1_cnt = 0; first_acc1 = -1; prev_mv1 = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", busy1, 0);

    // Continuous stream, downstream always ready.
    run_frame(0, 0, 0, 0);
    check("first_window_after_pixel_2_2", first_acc1, 19);
    check("last_window", q1.size() > 0 ? q1[q1.size() - 1] : -1, 3 * 16 + 5);
    check("lb_count_s2", acc2, 48);
    check_frame("cont");

    // Downstream stall at window (1,3).
    run_frame(0, 1, 0, 0);
    check_frame("stall");

    // Random input bubbles.
    run_frame(1, 0, 0, 0);
    check("lb_count_s2_bubbles", acc2, 48);
    check_frame("bubble");

    // Reset in the middle of row 3, then a fresh frame.
    run_frame(0, 0, 0, 27);
    check("abort_busy_before_reset", busy1, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(0, 0, 0, 0);
    check("post_reset_first", q1.size() > 0 ? q1[0] : -1, 0);
    check_frame("postreset");

    // start pulsed during RUN and in DONE must be ignored.
    run_frame(0, 0, 1, 0);
    check_frame("poke");
    repeat (4) @(posedge clk);
    #1;
    check("poke_idle_busy", busy1, 0);
    check("poke_idle_s_ready", s_ready1, 0);
    run_frame(0, 0, 0, 0);
    check_frame("restart");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
